// File: rtl/tx_serial_pkg.sv
// Shared types and constants for the parametrised serial transmitter.
package tx_serial_pkg;

  // Frame FSM states; codes are visible on the debug port.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_DATA   = 4'd2,
    ST_PARITY = 4'd3,
    ST_STOP   = 4'd4
  } tx_state_e;

  // Parity modes.
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // True when the parameter set describes a frame the transmitter can produce.
  function automatic bit tx_params_ok(int data_bits, int parity, int stop_bits, int divisor);
    return (data_bits >= 5) && (data_bits <= 8) &&
           (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (divisor >= 2);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear; fim marks the terminal count.
module contador_m #(
  parameter int M = 16,
  parameter int N = $clog2(M)
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam logic [N-1:0] LAST = N'(M - 1);

  logic [N-1:0] q_q, q_d;

  // Next count: clear wins, otherwise count 0..M-1 and wrap.
  always_comb begin
    q_d = q_q;
    if (zera_s) begin
      q_d = '0;
    end else if (conta) begin
      q_d = (q_q == LAST) ? '0 : q_q + N'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign fim = (q_q == LAST);

endmodule

// File: rtl/tx_serial_param.sv
// Parametrised UART-style transmitter with a one-word holding register.
module tx_serial_param
  import tx_serial_pkg::*;
#(
  parameter int DATA_BITS = 7,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1,
  parameter int DIVISOR   = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] dados,
  input  logic                 valido,
  output logic                 aceito,
  output logic                 saida_serial,
  output logic                 ocupado,
  output logic                 pronto,
  output logic                 db_tick,
  output logic [3:0]           db_estado
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  if (!tx_params_ok(DATA_BITS, PARITY, STOP_BITS, DIVISOR)) begin : g_bad_params
    $error("tx_serial_param: illegal DATA_BITS/PARITY/STOP_BITS/DIVISOR");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 cheio_q, cheio_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 line_q, line_d;
  logic                 tick;
  logic                 frame_start;

  contador_m #(
    .M(DIVISOR),
    .N($clog2(DIVISOR))
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .zera_s (frame_start),
    .conta  (1'b1),
    .fim    (tick)
  );

  // Handshake, frame sequencing and next line level.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    cheio_d     = cheio_q;
    shift_d     = shift_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    frame_start = 1'b0;
    pronto      = 1'b0;

    if (valido && !cheio_q) begin
      hold_d  = dados;
      cheio_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cheio_q) frame_start = 1'b1;
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            pronto    = 1'b1;
            bit_cnt_d = '0;
            if (cheio_q) frame_start = 1'b1;
            else         state_d     = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Parity is latched from the word at load time so shifting cannot disturb it.
    if (frame_start) begin
      shift_d   = hold_q;
      par_d     = (PARITY == PAR_EVEN) ? ^hold_q : ~^hold_q;
      cheio_d   = 1'b0;
      bit_cnt_d = '0;
      state_d   = ST_START;
    end

    // Line level follows the next state so the pin register changes with the FSM.
    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[0];
      ST_PARITY: line_d = par_d;
      default:   line_d = 1'b1;
    endcase
  end

  // State, data path and registered serial line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      cheio_q   <= 1'b0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      line_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cheio_q   <= cheio_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      line_q    <= line_d;
    end
  end

  assign aceito       = ~cheio_q;
  assign saida_serial = line_q;
  assign ocupado      = (state_q != ST_IDLE);
  assign db_tick      = tick;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_tx_serial_param.sv
// Self-checking bench for tx_serial_param: three parameterisations, frame scoreboard.
module tb_tx_serial_param;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [6:0] a_dados; logic a_valido, a_aceito, a_saida, a_ocupado, a_pronto, a_tick; logic [3:0] a_estado;
  logic [7:0] b_dados; logic b_valido, b_aceito, b_saida, b_ocupado, b_pronto, b_tick; logic [3:0] b_estado;
  logic [4:0] c_dados; logic c_valido, c_aceito, c_saida, c_ocupado, c_pronto, c_tick; logic [3:0] c_estado;

  tx_serial_param #(.DIVISOR(DIV)) u_a (
    .clock(clk), .reset(rst_n), .dados(a_dados), .valido(a_valido), .aceito(a_aceito),
    .saida_serial(a_saida), .ocupado(a_ocupado), .pronto(a_pronto), .db_tick(a_tick), .db_estado(a_estado));

  tx_serial_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIVISOR(DIV)) u_b (
    .clock(clk), .reset(rst_n), .dados(b_dados), .valido(b_valido), .aceito(b_aceito),
    .saida_serial(b_saida), .ocupado(b_ocupado), .pronto(b_pronto), .db_tick(b_tick), .db_estado(b_estado));

  tx_serial_param #(.DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .DIVISOR(DIV)) u_c (
    .clock(clk), .reset(rst_n), .dados(c_dados), .valido(c_valido), .aceito(c_aceito),
    .saida_serial(c_saida), .ocupado(c_ocupado), .pronto(c_pronto), .db_tick(c_tick), .db_estado(c_estado));

  int vectors    = 0;
  int miscompares = 0;
  logic exp_line[$];
  logic exp_pronto[$];

  // Expected line level and pronto for every cycle of one frame.
  task automatic push_frame(input logic [7:0] w, input int db, input int par, input int sb, input int div);
    logic bits[$];
    logic p;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      bits.push_back(w[i]);
      p = p ^ w[i];
    end
    if (par == 1) bits.push_back(~p);
    else if (par == 2) bits.push_back(p);
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++)
      for (int j = 0; j < div; j++) begin
        exp_line.push_back(bits[k]);
        exp_pronto.push_back((k == bits.size() - 1) && (j == div - 1));
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_dados = '0; a_valido = 1'b0;
    b_dados = '0; b_valido = 1'b0;
    c_dados = '0; c_valido = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (a_saida !== 1'b1)   begin miscompares++; $display("FAIL rst_line got %b exp 1", a_saida); end
    vectors++; if (a_aceito !== 1'b1)  begin miscompares++; $display("FAIL rst_aceito got %b exp 1", a_aceito); end
    vectors++; if (a_ocupado !== 1'b0) begin miscompares++; $display("FAIL rst_ocupado got %b exp 0", a_ocupado); end
    vectors++; if (a_pronto !== 1'b0)  begin miscompares++; $display("FAIL rst_pronto got %b exp 0", a_pronto); end
    vectors++; if (a_tick !== 1'b0)    begin miscompares++; $display("FAIL rst_tick got %b exp 0", a_tick); end
    vectors++; if (a_estado !== 4'd0)  begin miscompares++; $display("FAIL rst_estado got %0d exp 0", a_estado); end
    vectors++; if (b_saida !== 1'b1 || c_saida !== 1'b1) begin miscompares++; $display("FAIL rst_line_bc got %b%b exp 11", b_saida, c_saida); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (a_ocupado !== 1'b0 || a_saida !== 1'b1) begin miscompares++; $display("FAIL post_rst_idle got ocupado=%b line=%b exp 0/1", a_ocupado, a_saida); end
  endtask

  task automatic test_7o1();
    int pr_cyc = -1;
    int cyc;
    logic el, ep, et;
    push_frame(8'h41, 7, 1, 1, DIV);
    a_dados = 7'h41; a_valido = 1'b1;
    vectors++; if (a_aceito !== 1'b1) begin miscompares++; $display("FAIL 7o1_aceito_c0 got %b exp 1", a_aceito); end
    @(negedge clk); a_valido = 1'b0;
    vectors++; if (a_aceito !== 1'b0)  begin miscompares++; $display("FAIL 7o1_aceito_c1 got %b exp 0", a_aceito); end
    vectors++; if (a_ocupado !== 1'b0) begin miscompares++; $display("FAIL 7o1_ocupado_c1 got %b exp 0", a_ocupado); end
    @(negedge clk);
    vectors++; if (a_aceito !== 1'b1) begin miscompares++; $display("FAIL 7o1_aceito_c2 got %b exp 1", a_aceito); end
    cyc = 2;
    while (exp_line.size() > 0) begin
      el = exp_line.pop_front(); ep = exp_pronto.pop_front();
      et = (((cyc - 2) % DIV) == DIV - 1);
      vectors++; if (a_saida !== el)     begin miscompares++; $display("FAIL 7o1_line c%0d got %b exp %b", cyc, a_saida, el); end
      vectors++; if (a_pronto !== ep)    begin miscompares++; $display("FAIL 7o1_pronto c%0d got %b exp %b", cyc, a_pronto, ep); end
      vectors++; if (a_tick !== et)      begin miscompares++; $display("FAIL 7o1_tick c%0d got %b exp %b", cyc, a_tick, et); end
      vectors++; if (a_ocupado !== 1'b1) begin miscompares++; $display("FAIL 7o1_ocupado c%0d got %b exp 1", cyc, a_ocupado); end
      if (a_pronto === 1'b1) pr_cyc = cyc;
      @(negedge clk); cyc++;
    end
    vectors++; if (pr_cyc != 2 + 10 * DIV - 1) begin miscompares++; $display("FAIL 7o1_pronto_cycle got %0d exp %0d", pr_cyc, 2 + 10 * DIV - 1); end
    vectors++; if (a_ocupado !== 1'b0 || a_saida !== 1'b1 || a_estado !== 4'd0) begin
      miscompares++; $display("FAIL 7o1_end_idle got ocupado=%b line=%b estado=%0d exp 0/1/0", a_ocupado, a_saida, a_estado); end
  endtask

  task automatic test_8e2();
    int pr_cyc = -1;
    int cyc;
    logic el, ep;
    push_frame(8'hA5, 8, 2, 2, DIV);
    b_dados = 8'hA5; b_valido = 1'b1;
    @(negedge clk); b_valido = 1'b0;
    @(negedge clk);
    cyc = 2;
    while (exp_line.size() > 0) begin
      el = exp_line.pop_front(); ep = exp_pronto.pop_front();
      vectors++; if (b_saida !== el)  begin miscompares++; $display("FAIL 8e2_line c%0d got %b exp %b", cyc, b_saida, el); end
      vectors++; if (b_pronto !== ep) begin miscompares++; $display("FAIL 8e2_pronto c%0d got %b exp %b", cyc, b_pronto, ep); end
      if (b_pronto === 1'b1) pr_cyc = cyc;
      @(negedge clk); cyc++;
    end
    vectors++; if (pr_cyc != 2 + 12 * DIV - 1) begin miscompares++; $display("FAIL 8e2_frame_len got %0d exp %0d", pr_cyc, 2 + 12 * DIV - 1); end
    vectors++; if (b_ocupado !== 1'b0) begin miscompares++; $display("FAIL 8e2_end_idle got %b exp 0", b_ocupado); end
  endtask

  task automatic test_5n1();
    int pr_cyc = -1;
    int cyc;
    logic el, ep;
    push_frame(8'h1F, 5, 0, 1, DIV);
    c_dados = 5'h1F; c_valido = 1'b1;
    @(negedge clk); c_valido = 1'b0;
    @(negedge clk);
    cyc = 2;
    while (exp_line.size() > 0) begin
      el = exp_line.pop_front(); ep = exp_pronto.pop_front();
      vectors++; if (c_saida !== el)  begin miscompares++; $display("FAIL 5n1_line c%0d got %b exp %b", cyc, c_saida, el); end
      vectors++; if (c_pronto !== ep) begin miscompares++; $display("FAIL 5n1_pronto c%0d got %b exp %b", cyc, c_pronto, ep); end
      vectors++; if (c_estado === 4'd3) begin miscompares++; $display("FAIL 5n1_no_parity c%0d got estado %0d exp not 3", cyc, c_estado); end
      if (c_pronto === 1'b1) pr_cyc = cyc;
      @(negedge clk); cyc++;
    end
    vectors++; if (pr_cyc != 2 + 7 * DIV - 1) begin miscompares++; $display("FAIL 5n1_frame_len got %0d exp %0d", pr_cyc, 2 + 7 * DIV - 1); end
  endtask

  task automatic test_back_to_back();
    localparam int FL = 10 * DIV;
    logic [6:0] words [3];
    int idx;
    int acc_cyc[$];
    int pr_cyc[$];
    bit hs;
    logic el, ep;
    words = '{7'h55, 7'h2A, 7'h33};
    for (int i = 0; i < 3; i++) push_frame({1'b0, words[i]}, 7, 1, 1, DIV);
    idx = 0; a_dados = words[0]; a_valido = 1'b1;
    for (int cyc = 0; cyc <= 2 + 3 * FL; cyc++) begin
      if (cyc >= 2 && exp_line.size() > 0) begin
        el = exp_line.pop_front(); ep = exp_pronto.pop_front();
        vectors++; if (a_saida !== el)     begin miscompares++; $display("FAIL b2b_line c%0d got %b exp %b", cyc, a_saida, el); end
        vectors++; if (a_pronto !== ep)    begin miscompares++; $display("FAIL b2b_pronto c%0d got %b exp %b", cyc, a_pronto, ep); end
        vectors++; if (a_ocupado !== 1'b1) begin miscompares++; $display("FAIL b2b_ocupado c%0d got %b exp 1", cyc, a_ocupado); end
      end else if (cyc == 2 + 3 * FL) begin
        vectors++; if (a_ocupado !== 1'b0 || a_saida !== 1'b1) begin
          miscompares++; $display("FAIL b2b_end_idle got ocupado=%b line=%b exp 0/1", a_ocupado, a_saida); end
      end
      if (cyc >= 3 && cyc <= 1 + FL) begin
        vectors++; if (a_aceito !== 1'b0) begin miscompares++; $display("FAIL hold_full_aceito c%0d got %b exp 0", cyc, a_aceito); end
      end
      if (a_pronto === 1'b1) pr_cyc.push_back(cyc);
      hs = a_valido && a_aceito;
      if (hs) acc_cyc.push_back(cyc);
      @(negedge clk);
      if (hs) begin
        idx++;
        if (idx < 3) a_dados = words[idx];
        else a_valido = 1'b0;
      end
    end
    vectors++;
    if (acc_cyc.size() != 3) begin
      miscompares++; $display("FAIL b2b_accept_count got %0d exp 3", acc_cyc.size());
    end else if (acc_cyc[0] != 0 || acc_cyc[1] != 2 || acc_cyc[2] != 2 + FL) begin
      miscompares++; $display("FAIL b2b_accept_cycles got %0d,%0d,%0d exp 0,2,%0d", acc_cyc[0], acc_cyc[1], acc_cyc[2], 2 + FL);
    end
    vectors++;
    if (pr_cyc.size() != 3) begin
      miscompares++; $display("FAIL b2b_pronto_count got %0d exp 3", pr_cyc.size());
    end else if (pr_cyc[0] != 1 + FL || pr_cyc[1] - pr_cyc[0] != FL || pr_cyc[2] - pr_cyc[1] != FL) begin
      miscompares++; $display("FAIL b2b_pronto_spacing got %0d,%0d,%0d exp %0d,+%0d,+%0d", pr_cyc[0], pr_cyc[1], pr_cyc[2], 1 + FL, FL, FL);
    end
  endtask

  task automatic test_reset_mid();
    a_dados = 7'h41; a_valido = 1'b1;
    @(negedge clk); a_dados = 7'h2A;
    @(negedge clk);
    @(negedge clk); a_valido = 1'b0;
    repeat (8) @(negedge clk);
    // cycle 11: second data bit of 0x41 (a 0), second word held
    vectors++; if (a_estado !== 4'd2) begin miscompares++; $display("FAIL rmid_pre_state got %0d exp 2", a_estado); end
    vectors++; if (a_saida !== 1'b0)  begin miscompares++; $display("FAIL rmid_pre_line got %b exp 0", a_saida); end
    vectors++; if (a_aceito !== 1'b0) begin miscompares++; $display("FAIL rmid_pre_aceito got %b exp 0", a_aceito); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (a_saida !== 1'b1)   begin miscompares++; $display("FAIL rmid_async_line got %b exp 1", a_saida); end
    vectors++; if (a_ocupado !== 1'b0) begin miscompares++; $display("FAIL rmid_async_ocupado got %b exp 0", a_ocupado); end
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 25 * DIV; cyc++) begin
      @(negedge clk);
      vectors++; if (a_saida !== 1'b1 || a_ocupado !== 1'b0 || a_pronto !== 1'b0) begin
        miscompares++; $display("FAIL rmid_no_frame c%0d got line=%b ocupado=%b pronto=%b exp 1/0/0", cyc, a_saida, a_ocupado, a_pronto); end
      vectors++; if (a_aceito !== 1'b1 || a_estado !== 4'd0) begin
        miscompares++; $display("FAIL rmid_idle c%0d got aceito=%b estado=%0d exp 1/0", cyc, a_aceito, a_estado); end
    end
  endtask

  initial begin
    test_reset();
    test_7o1();
    test_8e2();
    test_5n1();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
